hazard_ctrl: RTL and testbench

Pipeline hazard and flush controller for the five-stage RISC-V core. It sits beside the ID stage and keeps a per-register scoreboard of in-flight register writes. From that scoreboard it stalls PC/IF-ID and inserts ID/EX bubbles on read-after-write hazards against the register file. It also sequences the squash of wrong-path instructions when EX resolves a taken branch or jump.

---
 rtl/hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and flush controller for the five-stage core.
//
// Keeps a 2-bit pending-write count per architectural register (x1..x31).
// Read-after-write hazards against in-flight writes stall PC and IF/ID and
// insert an ID/EX bubble. A taken branch in EX squashes IF/ID for
// FLUSH_CYCLES cycles.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   VALID_ID, RS1_ID, RS2_ID,   ID-stage instruction fields
//   RD_ID, USES_RS1_ID,
//   USES_RS2_ID, REG_WRITE_ID
//   RegWrite_WB, RD_WB          register-file write-back
//   BRANCH_TAKEN_EX             EX resolved a taken branch / jump
//   PC_WRITE, IF_ID_WRITE,      pipeline register controls
//   IF_ID_FLUSH, ID_EX_BUBBLE
//   STALL_CNT, FLUSH_CNT        saturating performance counters
//
// state  | meaning
// RUN    | normal issue, no stall or multi-cycle flush in progress
// STALL  | ID instruction held on a hazard
// FLUSH  | squashing wrong-path fetches after a taken branch
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             VALID_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [4:0]       RD_ID,
    input  logic             USES_RS1_ID,
    input  logic             USES_RS2_ID,
    input  logic             REG_WRITE_ID,
    input  logic             RegWrite_WB,
    input  logic [4:0]       RD_WB,
    input  logic             BRANCH_TAKEN_EX,
    output logic             PC_WRITE,
    output logic             IF_ID_WRITE,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // The branch cycle itself is one flush cycle; FLUSH covers the rest.
    localparam bit       USE_FLUSH_ST = (FLUSH_CYCLES > 1);
    localparam logic [2:0] FLUSH_LOAD = USE_FLUSH_ST ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    state_e           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [1:0]       sb_q [32];
    logic [1:0]       sb_d [32];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hazard;
    logic flush_act;
    logic issue;
    logic retire;
    logic stall_cyc;

    // Entry 0 is held at zero, so x0 can never raise a hazard.
    always_comb begin
        hazard    = VALID_ID & ((USES_RS1_ID  & (sb_q[RS1_ID] != 2'd0)) |
                                (USES_RS2_ID  & (sb_q[RS2_ID] != 2'd0)) |
                                (REG_WRITE_ID & (sb_q[RD_ID]  == 2'd3)));
        flush_act = BRANCH_TAKEN_EX | (state_q == ST_FLUSH);
        issue     = VALID_ID & REG_WRITE_ID & (RD_ID != 5'd0) & ~hazard & ~flush_act;
        retire    = RegWrite_WB & (RD_WB != 5'd0);
        stall_cyc = hazard & ~flush_act;
    end

    always_comb begin
        sb_d[0] = 2'd0;
        for (int i = 1; i < 32; i++) begin
            sb_d[i] = sb_q[i];
            unique case ({issue && (RD_ID == 5'(i)), retire && (RD_WB == 5'(i))})
                2'b10:   sb_d[i] = sb_q[i] + 2'd1;
                2'b01:   sb_d[i] = (sb_q[i] != 2'd0) ? sb_q[i] - 2'd1 : 2'd0;
                default: sb_d[i] = sb_q[i];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ST_RUN, ST_STALL: begin
                if (BRANCH_TAKEN_EX) begin
                    if (USE_FLUSH_ST) begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (hazard) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (BRANCH_TAKEN_EX) begin
                    fcnt_d = FLUSH_LOAD;
                end else if (fcnt_q == 3'd0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_cyc && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_act && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Outputs are forced safe while reset is held, independent of the clock.
    always_comb begin
        PC_WRITE     = 1'b1;
        IF_ID_WRITE  = 1'b1;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_BUBBLE = 1'b0;
        if (!rst_n) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            IF_ID_FLUSH  = 1'b0;
            ID_EX_BUBBLE = 1'b1;
        end else if (flush_act) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
        end else if (hazard) begin
            PC_WRITE     = 1'b0;
            IF_ID_WRITE  = 1'b0;
            ID_EX_BUBBLE = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            for (int i = 0; i < 32; i++) sb_q[i] <= 2'd0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            for (int i = 0; i < 32; i++) sb_q[i] <= sb_d[i];
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int FC  = 3;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk;
    logic          rst_n;
    logic          VALID_ID;
    logic [4:0]    RS1_ID, RS2_ID, RD_ID;
    logic          USES_RS1_ID, USES_RS2_ID, REG_WRITE_ID;
    logic          RegWrite_WB;
    logic [4:0]    RD_WB;
    logic          BRANCH_TAKEN_EX;
    logic          PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE;
    logic [CW-1:0] STALL_CNT, FLUSH_CNT;

    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .VALID_ID(VALID_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .RD_ID(RD_ID),
        .USES_RS1_ID(USES_RS1_ID), .USES_RS2_ID(USES_RS2_ID), .REG_WRITE_ID(REG_WRITE_ID),
        .RegWrite_WB(RegWrite_WB), .RD_WB(RD_WB), .BRANCH_TAKEN_EX(BRANCH_TAKEN_EX),
        .PC_WRITE(PC_WRITE), .IF_ID_WRITE(IF_ID_WRITE), .IF_ID_FLUSH(IF_ID_FLUSH),
        .ID_EX_BUBBLE(ID_EX_BUBBLE), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pending writes per register, remaining flush cycles,
    // and a 3-deep queue standing in for EX/MEM/WB of issued writers.
    int         pend [32];
    int         flush_left;
    int         m_stall, m_flush;
    logic [5:0] wbq [3];
    logic [3:0] exp_ctl;
    bit         exp_haz, exp_fl, exp_issue;
    int         cur_rd;
    bit         cur_bt;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        for (int i = 0; i < 3; i++) wbq[i] = 6'd0;
        flush_left = 0;
        m_stall    = 0;
        m_flush    = 0;
    endtask

    task automatic drive(input bit v, input int r1, input int r2, input int rd,
                         input bit u1, input bit u2, input bit rw, input bit bt);
        VALID_ID        = v;
        RS1_ID          = 5'(r1);
        RS2_ID          = 5'(r2);
        RD_ID           = 5'(rd);
        USES_RS1_ID     = u1;
        USES_RS2_ID     = u2;
        REG_WRITE_ID    = rw;
        BRANCH_TAKEN_EX = bt;
        if (wbq[2][5]) begin
            RegWrite_WB = 1'b1;
            RD_WB       = wbq[2][4:0];
        end else begin
            // Occasional write-back to x0, which must be ignored.
            RegWrite_WB = ($urandom_range(0, 7) == 0);
            RD_WB       = RegWrite_WB ? 5'd0 : 5'($urandom_range(0, 31));
        end
        exp_haz   = v && ((u1 && pend[r1] > 0) || (u2 && pend[r2] > 0) || (rw && pend[rd] == 3));
        exp_fl    = bt || (flush_left > 0);
        exp_ctl   = exp_fl ? 4'b1111 : (exp_haz ? 4'b0001 : 4'b1100);
        exp_issue = v && rw && (rd != 0) && !exp_haz && !exp_fl;
        cur_rd    = rd;
        cur_bt    = bt;
    endtask

    task automatic advance();
        @(posedge clk);
        if (exp_issue) pend[cur_rd]++;
        if (wbq[2][5]) pend[wbq[2][4:0]]--;
        if (exp_haz && !exp_fl && m_stall < SAT) m_stall++;
        if (exp_fl && m_flush < SAT) m_flush++;
        if (cur_bt) flush_left = FC - 1;
        else if (flush_left > 0) flush_left--;
        wbq[2] = wbq[1];
        wbq[1] = wbq[0];
        wbq[0] = exp_issue ? {1'b1, 5'(cur_rd)} : 6'd0;
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        drive(1, 3, 4, 5, 1, 1, 1, 0);
        #3;
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_ctl got %b exp %b", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, 4'b0001);
        end
        total++;
        if (STALL_CNT !== 4'd0 || FLUSH_CNT !== 4'd0) begin
            bad++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", STALL_CNT, FLUSH_CNT);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_release_ctl got %b exp %b", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, 4'b1100);
        end
        advance();
    endtask

    task automatic test_independent();
        for (int k = 0; k < 8; k++) begin
            drive(1, 20 + k, 28, 1 + k, 1, 1, 1, 0);
            @(negedge clk);
            total++;
            if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== exp_ctl) begin
                bad++;
                $display("FAIL indep_ctl[%0d] got %b exp %b", k, {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, exp_ctl);
            end
            advance();
        end
        drain(4);
        total++;
        if (STALL_CNT !== 4'd0) begin
            bad++;
            $display("FAIL indep_stall_cnt got %0d exp 0", STALL_CNT);
        end
    endtask

    task automatic test_load_use();
        int stalls = 0;
        drive(1, 1, 2, 5, 1, 1, 1, 0);
        @(negedge clk);
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== exp_ctl) begin
            bad++;
            $display("FAIL loaduse_prod_ctl got %b exp %b", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, exp_ctl);
        end
        advance();
        for (int k = 0; k < 8; k++) begin
            bit done;
            drive(1, 5, 1, 6, 1, 1, 1, 0);
            done = exp_issue;
            @(negedge clk);
            total++;
            if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== exp_ctl) begin
                bad++;
                $display("FAIL loaduse_ctl[%0d] got %b exp %b", k, {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, exp_ctl);
            end
            if (PC_WRITE === 1'b0) stalls++;
            advance();
            if (done) break;
        end
        total++;
        if (stalls != 3) begin
            bad++;
            $display("FAIL loaduse_stall_cycles got %0d exp 3", stalls);
        end
        total++;
        if (STALL_CNT !== 4'd3) begin
            bad++;
            $display("FAIL loaduse_stall_cnt got %0d exp 3", STALL_CNT);
        end
        drain(4);
        total++;
        if (dut.sb_q[5] !== 2'd0) begin
            bad++;
            $display("FAIL loaduse_sb5 got %0d exp 0", dut.sb_q[5]);
        end
    endtask

    task automatic test_x0();
        drive(1, 1, 2, 0, 1, 1, 1, 0);
        @(negedge clk);
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== 4'b1100) begin
            bad++;
            $display("FAIL x0_writer_ctl got %b exp %b", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, 4'b1100);
        end
        advance();
        drive(1, 0, 0, 11, 1, 1, 1, 0);
        @(negedge clk);
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== 4'b1100) begin
            bad++;
            $display("FAIL x0_reader_ctl got %b exp %b", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, 4'b1100);
        end
        advance();
        drain(4);
        total++;
        if (STALL_CNT !== 4'd3) begin
            bad++;
            $display("FAIL x0_stall_cnt got %0d exp 3", STALL_CNT);
        end
    endtask

    task automatic test_branch_hazard();
        int flushes = 0;
        drive(1, 1, 2, 9, 1, 1, 1, 0);
        advance();
        drive(1, 9, 1, 10, 1, 1, 1, 0);
        @(negedge clk);
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== 4'b0001) begin
            bad++;
            $display("FAIL branch_prestall_ctl got %b exp %b", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, 4'b0001);
        end
        advance();
        for (int k = 0; k < 4; k++) begin
            if (k == 0) drive(1, 9, 1, 10, 1, 1, 1, 1);
            else        drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            total++;
            if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== exp_ctl) begin
                bad++;
                $display("FAIL branch_ctl[%0d] got %b exp %b", k, {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, exp_ctl);
            end
            if (IF_ID_FLUSH === 1'b1) flushes++;
            advance();
        end
        total++;
        if (flushes != 3 || FLUSH_CNT !== 4'd3) begin
            bad++;
            $display("FAIL branch_flush_cycles got %0d/%0d exp 3/3", flushes, FLUSH_CNT);
        end
        total++;
        if (dut.sb_q[10] !== 2'd0) begin
            bad++;
            $display("FAIL branch_no_issue_sb10 got %0d exp 0", dut.sb_q[10]);
        end
        drain(4);
    endtask

    task automatic test_waw();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 7, 0, 0, 1, 0);
            @(negedge clk);
            total++;
            if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== exp_ctl) begin
                bad++;
                $display("FAIL waw_ctl[%0d] got %b exp %b", k, {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, exp_ctl);
            end
            if (k == 3) begin
                total++;
                if (PC_WRITE !== 1'b0) begin
                    bad++;
                    $display("FAIL waw_fourth_stall got %b exp 0", PC_WRITE);
                end
            end
            advance();
            if (k == 2) begin
                total++;
                if (dut.sb_q[7] !== 2'd3) begin
                    bad++;
                    $display("FAIL waw_sb7_full got %0d exp 3", dut.sb_q[7]);
                end
            end
            if (k == 4) begin
                total++;
                if (dut.sb_q[7] !== 2'd2) begin
                    bad++;
                    $display("FAIL waw_sb7_same_cycle got %0d exp 2", dut.sb_q[7]);
                end
            end
        end
        drain(4);
        total++;
        if (dut.sb_q[7] !== 2'd0) begin
            bad++;
            $display("FAIL waw_sb7_drained got %0d exp 0", dut.sb_q[7]);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 1, 2, 5, 1, 1, 1, 0);
        advance();
        drive(1, 1, 2, 5, 1, 1, 1, 0);
        advance();
        drive(1, 5, 1, 6, 1, 1, 1, 0);
        @(negedge clk);
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== 4'b0001 || dut.sb_q[5] !== 2'd2) begin
            bad++;
            $display("FAIL rstmid_stall got %b sb5=%0d exp 0001 sb5=2", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, dut.sb_q[5]);
        end
        #2;
        rst_n       = 1'b0;
        VALID_ID    = 1'b0;
        RegWrite_WB = 1'b0;
        #1;
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_ctl got %b exp %b", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, 4'b0001);
        end
        total++;
        if (STALL_CNT !== 4'd0 || FLUSH_CNT !== 4'd0) begin
            bad++;
            $display("FAIL rstmid_cnt got %0d/%0d exp 0/0", STALL_CNT, FLUSH_CNT);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        drive(1, 5, 1, 6, 1, 1, 1, 0);
        #1;
        total++;
        if (dut.sb_q[5] !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_sb5 got %0d exp 0", dut.sb_q[5]);
        end
        @(negedge clk);
        total++;
        if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== 4'b1100) begin
            bad++;
            $display("FAIL rstmid_reader_ctl got %b exp %b", {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, 4'b1100);
        end
        advance();
        drain(4);
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
            @(negedge clk);
            total++;
            if ({PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE} !== exp_ctl) begin
                bad++;
                $display("FAIL rand_ctl[%0d] got %b exp %b", k, {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE}, exp_ctl);
            end
            total++;
            if (STALL_CNT !== CW'(m_stall) || FLUSH_CNT !== CW'(m_flush)) begin
                bad++;
                $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", k, STALL_CNT, FLUSH_CNT, m_stall, m_flush);
            end
            advance();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_independent();
        test_load_use();
        test_x0();
        test_branch_hazard();
        test_waw();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
